// File: rtl/cpu_defs.sv
// cpu_defs: shared core types and constants for the 5-stage MIPS pipeline.
package cpu_defs;
    typedef logic        Bit_t;
    typedef logic [4:0]  Reg_addr_t;
    typedef logic [31:0] Word_t;
    typedef logic [63:0] DWord_t;
    typedef logic [1:0]  Acc_cnt_t;
    typedef logic [7:0]  Aluop_t;

    localparam Bit_t      ENABLE       = 1'b1;
    localparam Bit_t      DISABLE      = 1'b0;
    localparam Reg_addr_t REG_ZERO     = 5'd0;
    localparam Word_t     ZERO_WORD    = 32'd0;
    localparam DWord_t    ZERO_DWORD   = 64'd0;
    localparam Acc_cnt_t  ACC_CNT_IDLE = 2'd0;
    localparam Aluop_t    EXE_NOP_OP   = 8'h00;
endpackage

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register plus the MADD/MSUB accumulate state fed back to EX.
// Define EX_MEM_MEMOP_EN to also carry the load/store aluop, address and write data.
module ex_mem
    import cpu_defs::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_ex_i,
    input  logic             stall_mem_i,
    input  logic             flush_i,
    input  logic             wreg_write_i,
    input  logic [4:0]       wreg_addr_i,
    input  logic [31:0]      wreg_data_i,
    input  logic             whilo_i,
    input  logic [31:0]      hi_i,
    input  logic [31:0]      lo_i,
    input  logic [63:0]      hilo_temp_i,
    input  logic [CNT_W-1:0] cnt_i,
`ifdef EX_MEM_MEMOP_EN
    input  logic [7:0]       aluop_i,
    input  logic [31:0]      mem_addr_i,
    input  logic [31:0]      mem_wdata_i,
    output logic [7:0]       aluop_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
`endif
    output logic             wreg_write_o,
    output logic [4:0]       wreg_addr_o,
    output logic [31:0]      wreg_data_o,
    output logic             whilo_o,
    output logic [31:0]      hi_o,
    output logic [31:0]      lo_o,
    output logic [63:0]      hilo_temp_o,
    output logic [CNT_W-1:0] cnt_o
);
    typedef struct packed {
        Bit_t      wreg_write;
        Reg_addr_t wreg_addr;
        Word_t     wreg_data;
        Bit_t      whilo;
        Word_t     hi;
        Word_t     lo;
`ifdef EX_MEM_MEMOP_EN
        Aluop_t    aluop;
        Word_t     mem_addr;
        Word_t     mem_wdata;
`endif
    } pipe_t;

    pipe_t               r_pipe, w_in, w_clr;
    logic [63:0]         r_hilo_temp;
    logic [CNT_W-1:0]    r_cnt;

    always_comb begin
        w_in = '0;
        w_in.wreg_write = wreg_write_i;
        w_in.wreg_addr  = wreg_addr_i;
        w_in.wreg_data  = wreg_data_i;
        w_in.whilo      = whilo_i;
        w_in.hi         = hi_i;
        w_in.lo         = lo_i;
`ifdef EX_MEM_MEMOP_EN
        w_in.aluop      = aluop_i;
        w_in.mem_addr   = mem_addr_i;
        w_in.mem_wdata  = mem_wdata_i;
`endif
    end

    always_comb begin
        w_clr = '0;
        w_clr.wreg_write = DISABLE;
        w_clr.wreg_addr  = REG_ZERO;
        w_clr.wreg_data  = ZERO_WORD;
        w_clr.whilo      = DISABLE;
        w_clr.hi         = ZERO_WORD;
        w_clr.lo         = ZERO_WORD;
`ifdef EX_MEM_MEMOP_EN
        w_clr.aluop      = EXE_NOP_OP;
        w_clr.mem_addr   = ZERO_WORD;
        w_clr.mem_wdata  = ZERO_WORD;
`endif
    end

    // stall_mem_i alone (illegal) falls into the hold branch
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_pipe      <= w_clr;
            r_hilo_temp <= ZERO_DWORD;
            r_cnt       <= CNT_W'(ACC_CNT_IDLE);
        end else if (stall_mem_i) begin
            r_pipe      <= r_pipe;
            r_hilo_temp <= r_hilo_temp;
            r_cnt       <= r_cnt;
        end else if (stall_ex_i) begin
            r_pipe      <= w_clr;
            r_hilo_temp <= hilo_temp_i;
            r_cnt       <= cnt_i;
        end else begin
            r_pipe      <= w_in;
            r_hilo_temp <= ZERO_DWORD;
            r_cnt       <= CNT_W'(ACC_CNT_IDLE);
        end
    end

    assign wreg_write_o = r_pipe.wreg_write;
    assign wreg_addr_o  = r_pipe.wreg_addr;
    assign wreg_data_o  = r_pipe.wreg_data;
    assign whilo_o      = r_pipe.whilo;
    assign hi_o         = r_pipe.hi;
    assign lo_o         = r_pipe.lo;
    assign hilo_temp_o  = r_hilo_temp;
    assign cnt_o        = r_cnt;
`ifdef EX_MEM_MEMOP_EN
    assign aluop_o      = r_pipe.aluop;
    assign mem_addr_o   = r_pipe.mem_addr;
    assign mem_wdata_o  = r_pipe.mem_wdata;
`endif

    a_stall_order: assert property (@(posedge clk) disable iff (rst) stall_mem_i |-> stall_ex_i);
endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: directed vector table plus randomized run against a rule-level reference model.
module tb_ex_mem;
    logic        clk = 1'b0;
    logic        rst, stall_ex_i, stall_mem_i, flush_i;
    logic        wreg_write_i, whilo_i;
    logic [4:0]  wreg_addr_i;
    logic [31:0] wreg_data_i, hi_i, lo_i;
    logic [63:0] hilo_temp_i;
    logic [1:0]  cnt_i;
    logic        wreg_write_o, whilo_o;
    logic [4:0]  wreg_addr_o;
    logic [31:0] wreg_data_o, hi_o, lo_o;
    logic [63:0] hilo_temp_o;
    logic [1:0]  cnt_o;
`ifdef EX_MEM_MEMOP_EN
    logic [7:0]  aluop_i, aluop_o;
    logic [31:0] mem_addr_i, mem_addr_o, mem_wdata_i, mem_wdata_o;
`endif
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_mem #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst), .stall_ex_i(stall_ex_i), .stall_mem_i(stall_mem_i), .flush_i(flush_i),
        .wreg_write_i(wreg_write_i), .wreg_addr_i(wreg_addr_i), .wreg_data_i(wreg_data_i),
        .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i), .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
`ifdef EX_MEM_MEMOP_EN
        .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .aluop_o(aluop_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
`endif
        .wreg_write_o(wreg_write_o), .wreg_addr_o(wreg_addr_o), .wreg_data_o(wreg_data_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
    );

    typedef struct {
        logic rst, fl, sex, smem, ww;
        logic [4:0] wa;
        logic [31:0] wd;
        logic wh;
        logic [31:0] hi, lo;
        logic [63:0] ht;
        logic [1:0] cnt;
        logic e_ww;
        logic [4:0] e_wa;
        logic [31:0] e_wd;
        logic e_wh;
        logic [31:0] e_hi, e_lo;
        logic [63:0] e_ht;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t v[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ww, input logic [4:0] wa, input logic [31:0] wd,
                           input logic wh, input logic [31:0] hi, input logic [31:0] lo,
                           input logic [63:0] ht, input logic [1:0] cnt);
        chk({tag, ".wreg_write"}, 64'(wreg_write_o), 64'(ww));
        chk({tag, ".wreg_addr"}, 64'(wreg_addr_o), 64'(wa));
        chk({tag, ".wreg_data"}, 64'(wreg_data_o), 64'(wd));
        chk({tag, ".whilo"}, 64'(whilo_o), 64'(wh));
        chk({tag, ".hi"}, 64'(hi_o), 64'(hi));
        chk({tag, ".lo"}, 64'(lo_o), 64'(lo));
        chk({tag, ".hilo_temp"}, hilo_temp_o, ht);
        chk({tag, ".cnt"}, 64'(cnt_o), 64'(cnt));
    endtask

    // reference state: what the MEM side and the EX feedback should currently hold
    logic        m_ww, m_wh;
    logic [4:0]  m_wa;
    logic [31:0] m_wd, m_hi, m_lo;
    logic [63:0] m_ht;
    logic [1:0]  m_cnt;
`ifdef EX_MEM_MEMOP_EN
    logic [7:0]  m_op;
    logic [31:0] m_ma, m_mw;
`endif

    task automatic model_edge();
        bit kill = rst || flush_i;
        bit hold = !kill && stall_mem_i;
        bit bubble = !kill && !hold && stall_ex_i;
        if (hold) return;
        m_ww = (kill || bubble) ? 1'b0 : wreg_write_i;
        m_wa = (kill || bubble) ? 5'd0 : wreg_addr_i;
        m_wd = (kill || bubble) ? 32'd0 : wreg_data_i;
        m_wh = (kill || bubble) ? 1'b0 : whilo_i;
        m_hi = (kill || bubble) ? 32'd0 : hi_i;
        m_lo = (kill || bubble) ? 32'd0 : lo_i;
        m_ht = bubble ? hilo_temp_i : 64'd0;
        m_cnt = bubble ? cnt_i : 2'd0;
`ifdef EX_MEM_MEMOP_EN
        m_op = (kill || bubble) ? 8'h00 : aluop_i;
        m_ma = (kill || bubble) ? 32'd0 : mem_addr_i;
        m_mw = (kill || bubble) ? 32'd0 : mem_wdata_i;
`endif
    endtask

    initial begin
        {rst, stall_ex_i, stall_mem_i, flush_i, wreg_write_i, whilo_i} = '0;
        {wreg_addr_i, wreg_data_i, hi_i, lo_i, hilo_temp_i, cnt_i} = '0;
`ifdef EX_MEM_MEMOP_EN
        {aluop_i, mem_addr_i, mem_wdata_i} = '0;
`endif
        //           rst   fl    sex   smem  ww    wa     wd             wh    hi      lo      ht                     cnt    e_ww  e_wa   e_wd           e_wh  e_hi   e_lo   e_ht                   e_cnt
        v[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  32'hDEAD_BEEF, 1'b1, 32'h9,  32'h9,  64'h55,                2'd1,  1'b0, 5'd0,  32'h0,         1'b0, 32'h0, 32'h0, 64'h0,                 2'd0};
        v[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  32'hDEAD_BEEF, 1'b1, 32'h9,  32'h9,  64'h55,                2'd1,  1'b0, 5'd0,  32'h0,         1'b0, 32'h0, 32'h0, 64'h0,                 2'd0};
        v[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  32'hDEAD_BEEF, 1'b0, 32'h0,  32'h0,  64'h0,                 2'd0,  1'b1, 5'd3,  32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 64'h0,                 2'd0};
        v[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 32'h1,  32'h2,  64'hFF,                2'd3,  1'b0, 5'd0,  32'h0,         1'b1, 32'h1, 32'h2, 64'h0,                 2'd0};
        v[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7,  32'h1234,      1'b1, 32'h3,  32'h4,  64'h0000_0001_0000_0002, 2'd1, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0, 32'h0, 64'h0000_0001_0000_0002, 2'd1};
        v[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9,  32'hAAAA,      1'b1, 32'h6,  32'h6,  64'h77,                2'd2,  1'b0, 5'd0,  32'h0,         1'b0, 32'h0, 32'h0, 64'h0000_0001_0000_0002, 2'd1};
        v[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd31, 32'hBBBB,      1'b0, 32'h8,  32'h8,  64'h88,                2'd3,  1'b0, 5'd0,  32'h0,         1'b0, 32'h0, 32'h0, 64'h0000_0001_0000_0002, 2'd1};
        v[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1,  32'hCCCC,      1'b1, 32'hA,  32'hB,  64'h99,                2'd0,  1'b0, 5'd0,  32'h0,         1'b0, 32'h0, 32'h0, 64'h0000_0001_0000_0002, 2'd1};
        v[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 32'h5,  32'h7,  64'h1234,              2'd2,  1'b0, 5'd0,  32'h0,         1'b1, 32'h5, 32'h7, 64'h0,                 2'd0};
        v[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,  32'h0,  64'hABCD_0000_1111,    2'd1,  1'b0, 5'd0,  32'h0,         1'b0, 32'h0, 32'h0, 64'hABCD_0000_1111,    2'd1};
        v[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4,  32'h4444,      1'b1, 32'h4,  32'h4,  64'h4444,              2'd2,  1'b0, 5'd0,  32'h0,         1'b0, 32'h0, 32'h0, 64'h0,                 2'd0};
        v[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0BAD_F00D, 1'b1, 32'hE,  32'hF,  64'h0,                 2'd0,  1'b1, 5'd12, 32'h0BAD_F00D, 1'b1, 32'hE, 32'hF, 64'h0,                 2'd0};
        v[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd13, 32'h1,         1'b1, 32'h1,  32'h1,  64'h1,                 2'd1,  1'b0, 5'd0,  32'h0,         1'b0, 32'h0, 32'h0, 64'h0,                 2'd0};
        v[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF, 2'd3, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 2'd0};

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            rst = v[i].rst; flush_i = v[i].fl; stall_ex_i = v[i].sex; stall_mem_i = v[i].smem;
            wreg_write_i = v[i].ww; wreg_addr_i = v[i].wa; wreg_data_i = v[i].wd;
            whilo_i = v[i].wh; hi_i = v[i].hi; lo_i = v[i].lo; hilo_temp_i = v[i].ht; cnt_i = v[i].cnt;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), v[i].e_ww, v[i].e_wa, v[i].e_wd, v[i].e_wh,
                    v[i].e_hi, v[i].e_lo, v[i].e_ht, v[i].e_cnt);
        end

        @(negedge clk);
        rst = 1'b1; flush_i = 1'b0; stall_ex_i = 1'b0; stall_mem_i = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            chk_all($sformatf("rnd%0d", i), m_ww, m_wa, m_wd, m_wh, m_hi, m_lo, m_ht, m_cnt);
`ifdef EX_MEM_MEMOP_EN
            chk("rnd.aluop", 64'(aluop_o), 64'(m_op));
            chk("rnd.mem_addr", 64'(mem_addr_o), 64'(m_ma));
            chk("rnd.mem_wdata", 64'(mem_wdata_o), 64'(m_mw));
`endif
            @(negedge clk);
            rst = ($urandom_range(0, 49) == 0);
            flush_i = ($urandom_range(0, 19) == 0);
            stall_ex_i = ($urandom_range(0, 2) == 0);
            stall_mem_i = stall_ex_i && $urandom_range(0, 1);
            wreg_write_i = 1'($urandom);
            wreg_addr_i = 5'($urandom);
            wreg_data_i = $urandom;
            whilo_i = 1'($urandom);
            hi_i = $urandom;
            lo_i = $urandom;
            hilo_temp_i = {$urandom, $urandom};
            cnt_i = 2'($urandom);
`ifdef EX_MEM_MEMOP_EN
            aluop_i = 8'($urandom);
            mem_addr_i = $urandom;
            mem_wdata_i = $urandom;
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
